rvb_clmul_seq: RTL and testbench



---
 rtl/rvb_clmul_seq_if.sv | 26 ++
 rtl/rvb_clmul_seq.sv | 160 ++++++++++++++++
 tb/tb_rvb_clmul_seq.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rvb_clmul_seq_if.sv
// Operand/result handshake bundle for the iterative carry-less multiply unit.
// The master side offers operations and consumes results; the slave side is the unit.
interface rvb_clmul_seq_if #(
  parameter int XLEN = 64
);
  logic            din_valid;
  logic            din_ready;
  logic [XLEN-1:0] din_rs1;
  logic [XLEN-1:0] din_rs2;
  logic            din_insn3;
  logic            din_insn12;
  logic            din_insn13;
  logic            dout_valid;
  logic            dout_ready;
  logic [XLEN-1:0] dout_rd;

  modport master (
    output din_valid, din_rs1, din_rs2, din_insn3, din_insn12, din_insn13, dout_ready,
    input  din_ready, dout_valid, dout_rd
  );

  modport slave (
    input  din_valid, din_rs1, din_rs2, din_insn3, din_insn12, din_insn13, dout_ready,
    output din_ready, dout_valid, dout_rd
  );
endinterface

// File: rtl/rvb_clmul_seq.sv
// Iterative carry-less multiplier (CLMUL / CLMULH / CLMULR and RV64 W forms).
// rs2 is scanned LSB first, STEP bits per cycle, against a left-shifting copy
// of rs1 accumulated by XOR into a double-width product register.
// XLEN must be 32 or 64; STEP must be 1, 2, 4 or 8.
module rvb_clmul_seq #(
  parameter int XLEN = 64,
  parameter int STEP = 4
) (
  input logic           clock,
  input logic           resetn,
  rvb_clmul_seq_if.slave bus
);

  localparam int CNT_W = $clog2(XLEN / STEP);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(XLEN / STEP - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(32 / STEP - 1);
  localparam logic [XLEN-1:0]  LOW32    = XLEN'(64'h0000_0000_FFFF_FFFF);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic               din_ready_c;
  logic               dout_valid_c;
  logic               accept;
  logic               half_in;
  logic [XLEN-1:0]    rs1_in;
  logic [XLEN-1:0]    rs2_in;

  logic [CNT_W-1:0]   cnt;
  logic [2*XLEN-1:0]  acc;
  logic [2*XLEN-1:0]  acc_nxt;
  logic [2*XLEN-1:0]  mcd;
  logic [XLEN-1:0]    mpl;
  logic [1:0]         op_q;
  logic               half_q;
  logic [XLEN-1:0]    rd_q;

  // Select the architectural result from the full product; W forms take the
  // 32-bit window and sign-extend bit 31. The reserved encoding yields zero.
  function automatic logic [XLEN-1:0] pick_result(
    input logic [2*XLEN-1:0] a,
    input logic [1:0]        op,
    input logic              half
  );
    logic [XLEN-1:0] full_r;
    logic [31:0]     half_r;
    full_r = '0;
    half_r = '0;
    case (op)
      2'b01: begin
        full_r = a[XLEN-1:0];
        half_r = a[31:0];
      end
      2'b11: begin
        full_r = a[2*XLEN-1:XLEN];
        half_r = a[63:32];
      end
      2'b10: begin
        full_r = a[2*XLEN-2:XLEN-1];
        half_r = a[62:31];
      end
      default: begin
        full_r = '0;
        half_r = '0;
      end
    endcase
    return half ? XLEN'(signed'(half_r)) : full_r;
  endfunction

  // W forms only exist on RV64; operands are cut to 32 bits on capture for them.
  always_comb begin
    half_in = (XLEN == 64) && bus.din_insn3;
    rs1_in  = half_in ? (bus.din_rs1 & LOW32) : bus.din_rs1;
    rs2_in  = half_in ? (bus.din_rs2 & LOW32) : bus.din_rs2;
  end

  // Handshake outputs and next-state decode.
  always_comb begin
    state_nxt    = state;
    din_ready_c  = 1'b0;
    dout_valid_c = 1'b0;
    accept       = 1'b0;
    case (state)
      S_IDLE: begin
        din_ready_c = resetn;
        accept      = bus.din_valid && resetn;
        if (accept) state_nxt = S_BUSY;
      end
      S_BUSY: begin
        if (cnt == '0) state_nxt = S_DONE;
      end
      S_DONE: begin
        dout_valid_c = 1'b1;
        din_ready_c  = resetn && bus.dout_ready;
        accept       = bus.din_valid && din_ready_c;
        if (bus.dout_ready) state_nxt = bus.din_valid ? S_BUSY : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Slice counter: loaded with N-1 on accept, counts down to zero while busy.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= half_in ? CNT_HALF : CNT_FULL;
    end else if (state == S_BUSY && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // XOR in rs1 shifted by each set bit of the current rs2 slice.
  always_comb begin
    acc_nxt = acc;
    for (int j = 0; j < STEP; j++) begin
      if (mpl[j]) acc_nxt = acc_nxt ^ (mcd << j);
    end
  end

  // Operand capture and per-cycle slice processing.
  always_ff @(posedge clock) begin
    if (accept) begin
      acc    <= '0;
      mcd    <= {{XLEN{1'b0}}, rs1_in};
      mpl    <= rs2_in;
      op_q   <= {bus.din_insn13, bus.din_insn12};
      half_q <= half_in;
    end else if (state == S_BUSY) begin
      acc    <= acc_nxt;
      mcd    <= mcd << STEP;
      mpl    <= mpl >> STEP;
    end
  end

  // Result register: loaded on the final slice, held until the next result.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      rd_q <= '0;
    end else if (state == S_BUSY && cnt == '0) begin
      rd_q <= pick_result(acc_nxt, op_q, half_q);
    end
  end

  assign bus.din_ready  = din_ready_c;
  assign bus.dout_valid = dout_valid_c;
  assign bus.dout_rd    = rd_q;

endmodule

// File: tb/tb_rvb_clmul_seq.sv
// Bench for rvb_clmul_seq: one XLEN=64/STEP=4 unit plus XLEN=32 units at
// STEP 1, 2 and 8, checked against a bit-serial carry-less product model.
module tb_rvb_clmul_seq;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  rvb_clmul_seq_if #(.XLEN(64)) bus64();

  rvb_clmul_seq #(.XLEN(64), .STEP(4)) dut (
    .clock  (clk),
    .resetn (resetn),
    .bus    (bus64)
  );

  // Shared stimulus for the XLEN=32 sweep units.
  logic        v32_in = 1'b0;
  logic [31:0] a32 = '0;
  logic [31:0] b32 = '0;
  logic [1:0]  op32 = '0;
  logic        rdy32 = 1'b0;
  logic [2:0]  ov32;
  logic [2:0]  ir32;
  logic [31:0] ord32 [3];

  for (genvar k = 0; k < 3; k++) begin : g_sweep
    localparam int S = (k == 0) ? 1 : (k == 1) ? 2 : 8;
    rvb_clmul_seq_if #(.XLEN(32)) b();
    assign b.din_valid  = v32_in;
    assign b.din_rs1    = a32;
    assign b.din_rs2    = b32;
    assign b.din_insn3  = 1'b0;
    assign b.din_insn12 = op32[0];
    assign b.din_insn13 = op32[1];
    assign b.dout_ready = rdy32;
    rvb_clmul_seq #(.XLEN(32), .STEP(S)) u (
      .clock  (clk),
      .resetn (resetn),
      .bus    (b)
    );
    assign ov32[k]  = b.dout_valid;
    assign ir32[k]  = b.din_ready;
    assign ord32[k] = b.dout_rd;
  end

  // Reference: textbook carry-less product over w bits, then window select.
  function automatic logic [63:0] ref_clmul(input logic [63:0] a, input logic [63:0] b,
                                            input logic [1:0] op, input int w, input bit sext);
    logic [127:0] p;
    logic [63:0]  m;
    logic [63:0]  r;
    m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    a = a & m;
    b = b & m;
    p = '0;
    for (int i = 0; i < w; i++) if (b[i]) p = p ^ ({64'd0, a} << i);
    case (op)
      2'b01:   r = p[63:0] & m;
      2'b11:   r = 64'(p >> w) & m;
      2'b10:   r = 64'(p >> (w - 1)) & m;
      default: r = '0;
    endcase
    if (sext) r = {{32{r[31]}}, r[31:0]};
    return r;
  endfunction

  task automatic do_accept64(input logic [63:0] a, input logic [63:0] b, input logic i3,
                             input logic [1:0] op, input string tag);
    int   waited = 0;
    logic seen = 1'b0;
    bus64.din_rs1    = a;
    bus64.din_rs2    = b;
    bus64.din_insn3  = i3;
    bus64.din_insn12 = op[0];
    bus64.din_insn13 = op[1];
    bus64.din_valid  = 1'b1;
    while (!seen && waited < 100) begin
      @(negedge clk);
      seen = bus64.din_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    bus64.din_valid  = 1'b0;
    bus64.din_rs1    = {$urandom, $urandom};
    bus64.din_rs2    = {$urandom, $urandom};
    bus64.din_insn3  = 1'($urandom);
    bus64.din_insn12 = 1'($urandom);
    bus64.din_insn13 = 1'($urandom);
    tests++;
    if (seen !== 1'b1) begin
      fails++;
      $display("FAIL %s accept: din_ready=%b after %0d cycles, required 1", tag, seen, waited);
    end
  endtask

  task automatic wait_result64(output int lat);
    lat = 0;
    while (!bus64.dout_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run64(input logic [63:0] a, input logic [63:0] b, input logic i3,
                       input logic [1:0] op, input string tag);
    logic [63:0] exp;
    int          explat;
    int          lat;
    exp    = ref_clmul(a, b, op, i3 ? 32 : 64, i3);
    explat = i3 ? 8 : 16;
    do_accept64(a, b, i3, op, tag);
    wait_result64(lat);
    tests++;
    if (lat !== explat) begin
      fails++;
      $display("FAIL %s latency: got %0d, required %0d", tag, lat, explat);
    end
    tests++;
    if (bus64.dout_rd !== exp) begin
      fails++;
      $display("FAIL %s result: got %h, required %h", tag, bus64.dout_rd, exp);
    end
    bus64.dout_ready = 1'b1;
    @(posedge clk);
    #1;
    bus64.dout_ready = 1'b0;
    tests++;
    if (bus64.dout_valid !== 1'b0 || bus64.dout_rd !== exp) begin
      fails++;
      $display("FAIL %s hold: valid=%b rd=%h, required valid=0 rd=%h",
               tag, bus64.dout_valid, bus64.dout_rd, exp);
    end
  endtask

  task automatic test_reset;
    int vcount = 0;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (bus64.dout_valid !== 1'b0 || bus64.din_ready !== 1'b0 || bus64.dout_rd !== 64'd0) begin
      fails++;
      $display("FAIL reset_state: valid=%b ready=%b rd=%h, required 0 0 0",
               bus64.dout_valid, bus64.din_ready, bus64.dout_rd);
    end
    resetn = 1'b1;
    #1;
    tests++;
    if (bus64.din_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: got %b, required 1", bus64.din_ready);
    end
    // Leave a non-zero result behind, then reset in the middle of a new op.
    run64(64'd3, 64'd3, 1'b0, 2'b01, "pre_reset_op");
    do_accept64({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 2'b01, "mid_busy_op");
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (bus64.din_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_busy_ready_low: got %b, required 0", bus64.din_ready);
    end
    resetn = 1'b1;
    bus64.dout_ready = 1'b1;
    #1;
    tests++;
    if (bus64.din_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_busy_ready_after: got %b, required 1", bus64.din_ready);
    end
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (bus64.dout_valid) vcount++;
    end
    tests++;
    if (vcount !== 0) begin
      fails++;
      $display("FAIL reset_no_result: valid seen %0d cycles, required 0", vcount);
    end
    tests++;
    if (bus64.dout_rd !== 64'd0) begin
      fails++;
      $display("FAIL reset_rd_zero: got %h, required 0", bus64.dout_rd);
    end
    bus64.dout_ready = 1'b0;
  endtask

  task automatic test_directed;
    run64(64'd3, 64'd3, 1'b0, 2'b01, "clmul_3x3");
    run64(64'h8000_0000_0000_0000, 64'd2, 1'b0, 2'b11, "clmulh_msb");
    run64(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 2'b10, "clmulr_msb");
    run64(64'hFFFF_FFFF_8000_0000, 64'd3, 1'b1, 2'b01, "clmulw");
    run64(64'hFFFF_FFFF_8000_0000, 64'd3, 1'b1, 2'b11, "clmulhw");
    run64(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2'b00, "reserved");
    run64(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2'b10, "clmulr_ones");
  endtask

  task automatic test_random64;
    logic [1:0] ops [3] = '{2'b01, 2'b11, 2'b10};
    for (int i = 0; i < 12; i++) begin
      run64({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
            ops[$urandom_range(0, 2)], $sformatf("rand64_%0d", i));
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] a1, b1, a2, b2, exp1, exp2, held;
    int          lat;
    a1 = {$urandom, $urandom};
    b1 = {$urandom, $urandom};
    a2 = {$urandom, $urandom};
    b2 = {$urandom, $urandom};
    exp1 = ref_clmul(a1, b1, 2'b01, 64, 1'b0);
    exp2 = ref_clmul(a2, b2, 2'b11, 64, 1'b0);
    do_accept64(a1, b1, 1'b0, 2'b01, "b2b_first");
    wait_result64(lat);
    tests++;
    if (bus64.dout_rd !== exp1) begin
      fails++;
      $display("FAIL b2b_first_result: got %h, required %h", bus64.dout_rd, exp1);
    end
    held = bus64.dout_rd;
    bus64.din_rs1    = a2;
    bus64.din_rs2    = b2;
    bus64.din_insn3  = 1'b0;
    bus64.din_insn12 = 1'b1;
    bus64.din_insn13 = 1'b1;
    bus64.din_valid  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      tests++;
      if (bus64.dout_valid !== 1'b1 || bus64.dout_rd !== held || bus64.din_ready !== 1'b0) begin
        fails++;
        $display("FAIL stall_cycle_%0d: valid=%b rd=%h ready=%b, required 1 %h 0",
                 c, bus64.dout_valid, bus64.dout_rd, bus64.din_ready, held);
      end
    end
    bus64.dout_ready = 1'b1;
    #1;
    tests++;
    if (bus64.din_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_ready: got %b, required 1", bus64.din_ready);
    end
    @(posedge clk);
    #1;
    bus64.din_valid  = 1'b0;
    bus64.dout_ready = 1'b0;
    bus64.din_rs1    = {$urandom, $urandom};
    bus64.din_rs2    = {$urandom, $urandom};
    tests++;
    if (bus64.dout_valid !== 1'b0 || bus64.dout_rd !== held) begin
      fails++;
      $display("FAIL b2b_accepted: valid=%b rd=%h, required 0 %h",
               bus64.dout_valid, bus64.dout_rd, held);
    end
    wait_result64(lat);
    tests++;
    if (lat !== 16) begin
      fails++;
      $display("FAIL b2b_latency: got %0d, required 16", lat);
    end
    tests++;
    if (bus64.dout_rd !== exp2) begin
      fails++;
      $display("FAIL b2b_second_result: got %h, required %h", bus64.dout_rd, exp2);
    end
    bus64.dout_ready = 1'b1;
    @(posedge clk);
    #1;
    bus64.dout_ready = 1'b0;
  endtask

  task automatic test_sweep32;
    logic [1:0]  ops [7] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10};
    int          explat [3] = '{32, 16, 4};
    int          lat [3];
    logic [31:0] got [3];
    logic [2:0]  seen;
    logic [63:0] full;
    logic [31:0] exp;
    rdy32 = 1'b1;
    for (int r = 0; r < 7; r++) begin
      a32  = $urandom;
      b32  = $urandom;
      op32 = ops[r];
      full = ref_clmul({32'd0, a32}, {32'd0, b32}, op32, 32, 1'b0);
      exp  = full[31:0];
      tests++;
      if (ir32 !== 3'b111) begin
        fails++;
        $display("FAIL sweep_%0d_ready: got %b, required 111", r, ir32);
      end
      v32_in = 1'b1;
      @(posedge clk);
      #1;
      v32_in = 1'b0;
      a32    = $urandom;
      b32    = $urandom;
      op32   = 2'($urandom);
      seen   = '0;
      for (int k = 0; k < 3; k++) begin
        lat[k] = -1;
        got[k] = '0;
      end
      for (int c = 1; c <= 40; c++) begin
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
          if (!seen[k] && ov32[k]) begin
            seen[k] = 1'b1;
            lat[k]  = c;
            got[k]  = ord32[k];
          end
        end
      end
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (lat[k] !== explat[k]) begin
          fails++;
          $display("FAIL sweep_%0d_unit%0d_latency: got %0d, required %0d", r, k, lat[k], explat[k]);
        end
        tests++;
        if (got[k] !== exp) begin
          fails++;
          $display("FAIL sweep_%0d_unit%0d_result: got %h, required %h", r, k, got[k], exp);
        end
      end
    end
    rdy32 = 1'b0;
  endtask

  initial begin
    bus64.din_valid  = 1'b0;
    bus64.din_rs1    = '0;
    bus64.din_rs2    = '0;
    bus64.din_insn3  = 1'b0;
    bus64.din_insn12 = 1'b0;
    bus64.din_insn13 = 1'b0;
    bus64.dout_ready = 1'b0;
    test_reset;
    test_directed;
    test_random64;
    test_back_to_back;
    test_sweep32;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
